seq_divider: RTL
================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter DATA_WID, default 32, the width of dividend, divisor, quotient and remainder.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to begin a division; sampled on the rising edge of clk.
REQ-005 SHALL have port dividend, input, DATA_WID, unsigned numerator; captured on an accepted start.
REQ-006 SHALL have port divisor, input, DATA_WID, unsigned denominator; captured on an accepted start.
REQ-007 SHALL have port busy, output, 1, high while a division is in progress.
REQ-008 SHALL have port done, output, 1, single-cycle pulse when a result is valid.
REQ-009 SHALL have port quotient, output, DATA_WID, registered result quotient.
REQ-010 SHALL have port remainder, output, DATA_WID, registered result remainder.
REQ-011 SHALL have port div_by_zero, output, 1, registered flag for the last result; set when divisor was zero.

Function
REQ-012 SHALL implement unsigned restoring division with one quotient bit per cycle, MSB first.
REQ-013 SHALL use states IDLE, RUN and DONE.
REQ-014 In IDLE or DONE, start=1 SHALL be accepted: the block captures dividend and divisor and loads a bit counter with DATA_WID.
REQ-015 On acceptance with divisor != 0, the state SHALL go to RUN; with divisor == 0, it SHALL go directly to DONE.
REQ-016 Each RUN cycle SHALL shift {partial remainder, working dividend} left by one bit.
REQ-017 Each RUN cycle SHALL trial-subtract the divisor from the DATA_WID+1-bit partial remainder; if the result is non-negative, it keeps the difference and shifts in quotient bit 1, otherwise it restores and shifts in 0.
REQ-018 Each RUN cycle SHALL decrement the counter; RUN SHALL last exactly DATA_WID cycles, then go to DONE.
REQ-019 On entry to DONE, quotient, remainder and div_by_zero SHALL update together.
REQ-020 done SHALL be high for exactly one cycle, the cycle in DONE.
REQ-021 DONE SHALL return to IDLE after one cycle unless start=1 in that cycle, in which case a new operation is accepted (back-to-back).
REQ-022 Latency SHALL be: done high DATA_WID+1 cycles after the accepting edge for a non-zero divisor, and 1 cycle after for a zero divisor.
REQ-023 Divide by zero SHALL give quotient = all ones, remainder = dividend, div_by_zero = 1; any non-zero divisor SHALL give div_by_zero = 0.
REQ-024 busy SHALL equal (state == RUN).
REQ-025 start while busy SHALL be ignored, with no effect on the operation or the inputs captured.
REQ-026 Changes on dividend and divisor after acceptance SHALL NOT affect the result in progress.
REQ-027 quotient, remainder and div_by_zero SHALL hold their last values from DONE until the next DONE entry, including throughout RUN.
REQ-028 Results SHALL satisfy dividend = quotient*divisor + remainder and remainder < divisor for all non-zero divisors, including divisor = 1 and divisor > dividend.

Reset
REQ-029 rst=1 SHALL immediately force state IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0 and counter=0, regardless of clk.
REQ-030 rst asserted mid-RUN SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL be processed normally.

Verification
REQ-031 Bench SHALL cover 100/7 -> quotient=14, remainder=2, div_by_zero=0, done exactly 33 cycles after the accepting edge, busy high for 32 cycles.
REQ-032 Bench SHALL cover 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0; and 3/10 -> quotient=0, remainder=3.
REQ-033 Bench SHALL cover 5/0 -> quotient=0xFFFFFFFF, remainder=5, div_by_zero=1, done 1 cycle after acceptance, busy never high.
REQ-034 Bench SHALL cover start pulsed with different operands at cycle 10 of RUN -> ignored; the original result completes on schedule.
REQ-035 Bench SHALL cover rst at cycle 15 of RUN -> all outputs 0 and no done; a subsequent 81/9 -> quotient=9, remainder=0.
REQ-036 Bench SHALL cover start held high across DONE -> back-to-back operations with done pulses 33 cycles apart, plus 10,000 random operand pairs checked against REQ-028.

Source files
------------

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, MSB first.
// A division by zero skips the iteration and reports all-ones / dividend.
module seq_divider #(
  parameter int DATA_WID = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DATA_WID-1:0] dividend,
  input  logic [DATA_WID-1:0] divisor,
  output logic                busy,
  output logic                done,
  output logic [DATA_WID-1:0] quotient,
  output logic [DATA_WID-1:0] remainder,
  output logic                div_by_zero
);

  localparam int CNT_W = $clog2(DATA_WID + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    count;
  logic [DATA_WID-1:0] part_rem;
  logic [DATA_WID-1:0] work;
  logic [DATA_WID-1:0] dvsr;

  logic [DATA_WID:0]   shifted;
  logic [DATA_WID:0]   trial;
  logic [DATA_WID-1:0] next_rem;
  logic [DATA_WID-1:0] next_work;

  assign busy = (state == RUN);

  // One restoring step: shift the next dividend bit into the partial remainder,
  // trial-subtract the divisor and keep the difference only if it did not borrow.
  always_comb begin
    shifted   = {part_rem, work[DATA_WID-1]};
    trial     = shifted - {1'b0, dvsr};
    next_rem  = trial[DATA_WID-1:0];
    next_work = {work[DATA_WID-2:0], 1'b1};
    if (trial[DATA_WID]) begin
      next_rem  = shifted[DATA_WID-1:0];
      next_work = {work[DATA_WID-2:0], 1'b0};
    end
  end

  // Control FSM with datapath and registered result/handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      part_rem    <= '0;
      work        <= '0;
      dvsr        <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            dvsr     <= divisor;
            work     <= dividend;
            part_rem <= '0;
            count    <= CNT_W'(DATA_WID);
            if (divisor == '0) begin
              state       <= DONE;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
            end else begin
              state <= RUN;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          part_rem <= next_rem;
          work     <= next_work;
          count    <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state       <= DONE;
            quotient    <= next_work;
            remainder   <= next_rem;
            div_by_zero <= 1'b0;
            done        <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
